// File: rtl/flash_pkg.sv
// Shared types and defaults for the SPI flash read / FIFO fill controller.
package flash_pkg;

    localparam int              W_DEF         = 8;
    localparam int              ADDR_W_DEF    = 24;
    localparam int              LEN_W_DEF     = 16;
    localparam logic [7:0]      RD_OPCODE_DEF = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SEND_CMD,
        ST_SEND_ADDR,
        ST_DATA_ISSUE,
        ST_DATA_WAIT,
        ST_CS_HOLD,
        ST_FINISH
    } fill_state_t;

endpackage

// File: rtl/flash_fifo_fill_ctrl.sv
// SPI flash READ sequencer that streams returned bytes into fifo_buffer.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for cmd_start; cs_n high
// CS_SETUP    | one cycle of chip-select to first clock margin
// SEND_CMD    | shifting out the read opcode
// SEND_ADDR   | shifting out the address, MSB byte first
// DATA_ISSUE  | start a dummy-byte exchange once the FIFO has room
// DATA_WAIT   | byte in flight; on completion write it to the FIFO
// CS_HOLD     | one cycle hold before releasing chip select
// FINISH      | pulse done (aborted qualifies it), drop busy
module flash_fifo_fill_ctrl
    import flash_pkg::*;
#(
    parameter int              W         = W_DEF,
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter int              LEN_W     = LEN_W_DEF,
    parameter logic [W-1:0]    RD_OPCODE = W'(RD_OPCODE_DEF)
) (
    input  logic              system_clk,
    input  logic              system_reset_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              spi_cs_n,
    output logic              spi_go,
    output logic [W-1:0]      spi_tx_byte,
    input  logic [W-1:0]      spi_rx_byte,
    input  logic              spi_byte_done,
    input  logic              fifo_full,
    output logic              write_req,
    output logic [W-1:0]      fifo_dataIn
);

    localparam int ADDR_BYTES = ADDR_W / W;
    localparam int IDX_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_BYTES - 1);

    fill_state_t        state;
    logic [ADDR_W-1:0]  addr_sh;
    logic [LEN_W-1:0]   len_rem;
    logic [IDX_W-1:0]   byte_idx;
    logic               in_flight;
    logic               abort_pend;
    logic               abort_seen;

    // an abort arriving in the same cycle as a byte boundary counts immediately
    assign abort_seen = abort_pend | cmd_abort;

    // Main sequencer: state, counters and all registered outputs.
    // A FIFO write is only visible in fifo_full one cycle after write_req, so
    // DATA_ISSUE waits out the write_req cycle before trusting the flag.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_go      <= 1'b0;
            spi_tx_byte <= '0;
            write_req   <= 1'b0;
            fifo_dataIn <= '0;
            addr_sh     <= '0;
            len_rem     <= '0;
            byte_idx    <= '0;
            in_flight   <= 1'b0;
            abort_pend  <= 1'b0;
        end else begin
            spi_go    <= 1'b0;
            write_req <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            if (state != ST_IDLE && cmd_abort)
                abort_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    abort_pend <= 1'b0;
                    in_flight  <= 1'b0;
                    byte_idx   <= '0;
                    if (cmd_start) begin
                        busy <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            addr_sh  <= cmd_addr;
                            len_rem  <= cmd_len;
                            spi_cs_n <= 1'b0;
                            state    <= ST_CS_SETUP;
                        end
                    end
                end
                ST_CS_SETUP: state <= ST_SEND_CMD;
                ST_SEND_CMD: begin
                    if (!in_flight) begin
                        spi_go      <= 1'b1;
                        spi_tx_byte <= RD_OPCODE;
                        in_flight   <= 1'b1;
                    end else if (spi_byte_done) begin
                        in_flight <= 1'b0;
                        state     <= abort_seen ? ST_CS_HOLD : ST_SEND_ADDR;
                    end
                end
                ST_SEND_ADDR: begin
                    if (!in_flight) begin
                        spi_go      <= 1'b1;
                        spi_tx_byte <= addr_sh[ADDR_W-1 -: W];
                        in_flight   <= 1'b1;
                    end else if (spi_byte_done) begin
                        in_flight <= 1'b0;
                        addr_sh   <= addr_sh << W;
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            state    <= abort_seen ? ST_CS_HOLD : ST_DATA_ISSUE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            if (abort_seen)
                                state <= ST_CS_HOLD;
                        end
                    end
                end
                ST_DATA_ISSUE: begin
                    if (abort_seen) begin
                        state <= ST_CS_HOLD;
                    end else if (!fifo_full && !write_req) begin
                        spi_go      <= 1'b1;
                        spi_tx_byte <= '0;
                        state       <= ST_DATA_WAIT;
                    end
                end
                ST_DATA_WAIT: begin
                    if (spi_byte_done) begin
                        write_req   <= 1'b1;
                        fifo_dataIn <= spi_rx_byte;
                        len_rem     <= len_rem - 1'b1;
                        if (len_rem == LEN_W'(1) || abort_seen)
                            state <= ST_CS_HOLD;
                        else
                            state <= ST_DATA_ISSUE;
                    end
                end
                ST_CS_HOLD: begin
                    spi_cs_n <= 1'b1;
                    state    <= ST_FINISH;
                end
                ST_FINISH: begin
                    done    <= 1'b1;
                    aborted <= abort_seen;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_fifo_fill_ctrl.sv
// Directed bench: SPI flash responder and FIFO models around the fill controller.
module tb_flash_fifo_fill_ctrl;

    logic        system_clk = 1'b0;
    logic        system_reset_n;
    logic        cmd_start;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_abort;
    logic        busy, done, aborted, spi_cs_n, spi_go, write_req;
    logic [7:0]  spi_tx_byte, fifo_dataIn;
    logic [7:0]  spi_rx_byte = 8'h00;
    logic        spi_byte_done = 1'b0;
    logic        fifo_full = 1'b0;
    logic        rd_en;

    int total = 0;
    int passed = 0;

    flash_fifo_fill_ctrl dut (
        .system_clk     (system_clk),
        .system_reset_n (system_reset_n),
        .cmd_start      (cmd_start),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_abort      (cmd_abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .spi_cs_n       (spi_cs_n),
        .spi_go         (spi_go),
        .spi_tx_byte    (spi_tx_byte),
        .spi_rx_byte    (spi_rx_byte),
        .spi_byte_done  (spi_byte_done),
        .fifo_full      (fifo_full),
        .write_req      (write_req),
        .fifo_dataIn    (fifo_dataIn)
    );

    always #5 system_clk = ~system_clk;

    // SPI flash responder: each go completes 4 cycles later; data bytes of a
    // command come back as 00,01,02... (first four exchanges are cmd/addr).
    int         go_mark = 0;
    int         go_cnt = 0;
    int         lat_cnt = 0;
    int         go_csn_err = 0;
    int         cs_low_cnt = 0;
    logic [7:0] rx_pend = 8'h00;
    logic [7:0] mosi_log[$];

    always @(negedge system_clk) begin
        if (spi_byte_done) spi_byte_done = 1'b0;
        if (!spi_cs_n) cs_low_cnt++;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                spi_byte_done = 1'b1;
                spi_rx_byte   = rx_pend;
            end
        end
        if (spi_go) begin
            if (spi_cs_n) go_csn_err++;
            mosi_log.push_back(spi_tx_byte);
            rx_pend = 8'(go_cnt - go_mark - 4);
            go_cnt++;
            lat_cnt = 4;
        end
    end

    // FIFO model with programmable depth; full is registered like a real FIFO.
    int         fifo_depth = 16;
    int         wr_cnt = 0;
    int         overflow = 0;
    int         consec_err = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] rd_log[$];

    always @(posedge system_clk) begin
        if (write_req) begin
            wr_cnt++;
            if (prev_wr) consec_err++;
            if (fifo_q.size() >= fifo_depth) overflow++;
            else fifo_q.push_back(fifo_dataIn);
        end
        prev_wr <= write_req;
        if (rd_en && fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
        fifo_full <= (fifo_q.size() >= fifo_depth);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_cmd(input logic [23:0] a, input logic [15:0] l);
        @(negedge system_clk);
        cmd_start = 1'b1; cmd_addr = a; cmd_len = l;
        @(negedge system_clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int max, output logic got, output logic ab);
        got = 1'b0; ab = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge system_clk);
            if (done === 1'b1) begin got = 1'b1; ab = aborted; break; end
        end
    endtask

    task automatic wait_go(input int target, input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge system_clk);
            if (go_cnt - go_mark >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_wr(input int target, input int max, output logic ok);
        int base;
        base = wr_cnt;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge system_clk);
            if (wr_cnt - base >= target) begin ok = 1'b1; break; end
        end
    endtask

    logic [7:0] exp_b [0:15];

    task automatic check_mosi(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (go_mark + i < mosi_log.size())
                check($sformatf("%s_b%0d", tag, i), 32'(mosi_log[go_mark + i]), 32'(exp_b[i]));
            else
                check($sformatf("%s_b%0d_missing", tag, i), 32'h0, 32'h1);
        end
    endtask

    task automatic pop_check(input string tag, input int n, input int first);
        int mark;
        mark = rd_log.size();
        @(negedge system_clk);
        rd_en = 1'b1;
        repeat (n) @(negedge system_clk);
        rd_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mark + i < rd_log.size())
                check($sformatf("%s_rd%0d", tag, i), 32'(rd_log[mark + i]), 32'(first + i));
            else
                check($sformatf("%s_rd%0d_missing", tag, i), 32'h0, 32'h1);
        end
    endtask

    initial begin
        logic got, ab, ok;
        int   wr_mark, go_snap, cs_snap;

        system_reset_n = 1'b0;
        cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_abort = 1'b0; rd_en = 1'b0;
        repeat (3) @(negedge system_clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_go", 32'(spi_go), 32'd0);
        check("rst_tx", 32'(spi_tx_byte), 32'd0);
        check("rst_wr", 32'(write_req), 32'd0);
        check("rst_din", 32'(fifo_dataIn), 32'd0);
        system_reset_n = 1'b1;
        repeat (2) @(negedge system_clk);

        // basic read: addr 000100, 5 bytes
        go_mark = go_cnt; wr_mark = wr_cnt; fifo_depth = 16;
        start_cmd(24'h000100, 16'd5);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(400, got, ab);
        check("t1_done_seen", 32'(got), 32'd1);
        check("t1_aborted", 32'(ab), 32'd0);
        check("t1_gos", 32'(go_cnt - go_mark), 32'd9);
        exp_b[0] = 8'h03; exp_b[1] = 8'h00; exp_b[2] = 8'h01; exp_b[3] = 8'h00;
        for (int i = 4; i < 9; i++) exp_b[i] = 8'h00;
        check_mosi("t1_mosi", 9);
        check("t1_writes", 32'(wr_cnt - wr_mark), 32'd5);
        @(negedge system_clk);
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check("t1_cs_n_after", 32'(spi_cs_n), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);
        pop_check("t1", 5, 0);

        // zero length: no SPI activity, done one cycle after acceptance
        go_mark = go_cnt; cs_snap = cs_low_cnt;
        start_cmd(24'h000040, 16'd0);
        check("t2_busy_c0", 32'(busy), 32'd1);
        check("t2_done_c0", 32'(done), 32'd0);
        @(negedge system_clk);
        check("t2_done_c1", 32'(done), 32'd1);
        check("t2_busy_c1", 32'(busy), 32'd0);
        check("t2_aborted", 32'(aborted), 32'd0);
        @(negedge system_clk);
        check("t2_done_c2", 32'(done), 32'd0);
        check("t2_gos", 32'(go_cnt - go_mark), 32'd0);
        check("t2_cs_low", 32'(cs_low_cnt - cs_snap), 32'd0);

        // back-pressure: depth 4, 6 bytes, stall until two entries are read
        go_mark = go_cnt; wr_mark = wr_cnt; fifo_depth = 4;
        start_cmd(24'h000200, 16'd6);
        wait_wr(4, 400, ok);
        check("t3_four_writes_seen", 32'(ok), 32'd1);
        go_snap = go_cnt;
        repeat (20) @(negedge system_clk);
        check("t3_stall_no_go", 32'(go_cnt - go_snap), 32'd0);
        check("t3_stall_writes", 32'(wr_cnt - wr_mark), 32'd4);
        check("t3_stall_cs_n", 32'(spi_cs_n), 32'd0);
        check("t3_stall_busy", 32'(busy), 32'd1);
        pop_check("t3a", 2, 0);
        wait_done(400, got, ab);
        check("t3_done_seen", 32'(got), 32'd1);
        check("t3_aborted", 32'(ab), 32'd0);
        check("t3_writes", 32'(wr_cnt - wr_mark), 32'd6);
        check("t3_overflow", 32'(overflow), 32'd0);
        pop_check("t3b", 4, 2);
        fifo_depth = 16;

        // abort during the third data byte
        go_mark = go_cnt; wr_mark = wr_cnt;
        start_cmd(24'h000300, 16'd10);
        wait_go(7, 400, ok);
        check("t4_third_go_seen", 32'(ok), 32'd1);
        cmd_abort = 1'b1;
        @(negedge system_clk);
        cmd_abort = 1'b0;
        wait_done(400, got, ab);
        check("t4_done_seen", 32'(got), 32'd1);
        check("t4_aborted", 32'(ab), 32'd1);
        check("t4_writes", 32'(wr_cnt - wr_mark), 32'd3);
        check("t4_gos", 32'(go_cnt - go_mark), 32'd7);
        pop_check("t4", 3, 0);

        // reset in the middle of the address phase, then a clean command
        go_mark = go_cnt; wr_mark = wr_cnt;
        start_cmd(24'h000100, 16'd5);
        wait_go(2, 400, ok);
        check("t5_addr_phase_seen", 32'(ok), 32'd1);
        system_reset_n = 1'b0;
        #1;
        check("t5_rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("t5_rst_wr", 32'(write_req), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_go", 32'(spi_go), 32'd0);
        repeat (6) @(negedge system_clk);
        check("t5_rst_hold_cs_n", 32'(spi_cs_n), 32'd1);
        check("t5_rst_no_done", 32'(done), 32'd0);
        system_reset_n = 1'b1;
        repeat (2) @(negedge system_clk);
        check("t5_no_writes", 32'(wr_cnt - wr_mark), 32'd0);
        go_mark = go_cnt; wr_mark = wr_cnt;
        start_cmd(24'h123456, 16'd2);
        wait_done(400, got, ab);
        check("t5_done_seen", 32'(got), 32'd1);
        check("t5_aborted", 32'(ab), 32'd0);
        exp_b[0] = 8'h03; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h56;
        exp_b[4] = 8'h00; exp_b[5] = 8'h00;
        check("t5_gos", 32'(go_cnt - go_mark), 32'd6);
        check_mosi("t5_mosi", 6);
        check("t5_writes", 32'(wr_cnt - wr_mark), 32'd2);
        pop_check("t5", 2, 0);

        // a second cmd_start while busy must be ignored
        go_mark = go_cnt; wr_mark = wr_cnt;
        start_cmd(24'hABCDEF, 16'd3);
        wait_go(2, 400, ok);
        check("t6_busy_phase_seen", 32'(ok), 32'd1);
        cmd_start = 1'b1; cmd_addr = 24'h111111; cmd_len = 16'd9;
        @(negedge system_clk);
        cmd_start = 1'b0;
        wait_done(400, got, ab);
        check("t6_done_seen", 32'(got), 32'd1);
        check("t6_aborted", 32'(ab), 32'd0);
        exp_b[0] = 8'h03; exp_b[1] = 8'hAB; exp_b[2] = 8'hCD; exp_b[3] = 8'hEF;
        for (int i = 4; i < 7; i++) exp_b[i] = 8'h00;
        check_mosi("t6_mosi", 7);
        check("t6_writes", 32'(wr_cnt - wr_mark), 32'd3);
        repeat (10) @(negedge system_clk);
        check("t6_gos_no_restart", 32'(go_cnt - go_mark), 32'd7);
        check("t6_idle_busy", 32'(busy), 32'd0);
        pop_check("t6", 3, 0);

        check("glb_consec_wr", 32'(consec_err), 32'd0);
        check("glb_go_cs_high", 32'(go_csn_err), 32'd0);
        check("glb_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/flash_fifo_fill_ctrl.md
Name: flash_fifo_fill_ctrl

Overview:
- Sequences a SPI flash READ (opcode 0x03) and streams the returned bytes into fifo_buffer through its write_req/fifo_dataIn port.
- Sits between the command source (host logic) and two blocks: the SPI byte-shift master and fifo_buffer.
- Owns chip-select framing, byte counting and back-pressure from FIFO full. The FIFO's read side belongs to the consumer.

Parameters:
- W, 8, data width; must equal the fifo_buffer W.
- ADDR_W, 24, flash address width; sent as ADDR_W/8 bytes, MSB first.
- LEN_W, 16, width of the byte-count field.
- RD_OPCODE, 8'h03, read opcode sent first.

Ports:
- system_clk  in  1  single system clock, rising edge.
- system_reset_n  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle start pulse; accepted only in IDLE.
- cmd_addr  in  ADDR_W  start address; sampled on an accepted cmd_start.
- cmd_len  in  LEN_W  number of data bytes; sampled on an accepted cmd_start.
- cmd_abort  in  1  ends the transfer early.
- busy  out  1  high from start acceptance until the cycle done pulses.
- done  out  1  one-cycle pulse at the end of a transfer.
- aborted  out  1  qualifies done; high when the transfer ended by abort.
- spi_cs_n  out  1  flash chip select, active low.
- spi_go  out  1  one-cycle pulse that starts one byte exchange.
- spi_tx_byte  out  W  byte to shift out; held stable while a byte is in flight.
- spi_rx_byte  in  W  received byte; valid when spi_byte_done is high.
- spi_byte_done  in  1  one-cycle pulse when a byte exchange completes.
- fifo_full  in  1  fifo_buffer full flag.
- write_req  out  1  one-cycle FIFO write strobe.
- fifo_dataIn  out  W  FIFO write data.

Behaviour:
- Reset values: busy=0, done=0, aborted=0, spi_cs_n=1, spi_go=0, spi_tx_byte=0, write_req=0, fifo_dataIn=0. State is IDLE, all counters are 0.
- All outputs are registered.
- States: IDLE, CS_SETUP, SEND_CMD, SEND_ADDR, DATA_ISSUE, DATA_WAIT, CS_HOLD, FINISH.
- IDLE, on cmd_start:
  - cmd_len==0: go straight to FINISH. done pulses the next cycle; spi_cs_n never toggles.
  - Otherwise: latch addr/len, busy=1, spi_cs_n=0, go to CS_SETUP.
  - cmd_start outside IDLE is ignored.
- CS_SETUP: one cycle of CS-to-first-clock margin, then SEND_CMD.
- SEND_CMD:
  - Pulse spi_go with spi_tx_byte=RD_OPCODE.
  - Wait for spi_byte_done, then go to SEND_ADDR.
- SEND_ADDR:
  - Send ADDR_W/8 bytes, MSB first, each as an spi_go pulse followed by a wait for spi_byte_done.
  - Byte index counter wraps back to 0 after the last byte.
- DATA_ISSUE:
  - If fifo_full=1: stall and issue nothing; spi_cs_n stays low.
  - If fifo_full=0: pulse spi_go with spi_tx_byte=8'h00 and go to DATA_WAIT.
  - The controller is the FIFO's only writer, so checking full at issue time guarantees space at write time.
- DATA_WAIT, on spi_byte_done:
  - Next cycle: write_req=1 for exactly one cycle, fifo_dataIn=spi_rx_byte.
  - Remaining count decrements.
  - Count reaches 0: go to CS_HOLD. Otherwise return to DATA_ISSUE.
- Throughput: at most one write_req per byte exchange; never two consecutive write_req cycles.
- CS_HOLD: one cycle, then spi_cs_n=1 and go to FINISH.
- FINISH:
  - done=1 for one cycle, busy=0, return to IDLE.
  - aborted is valid only while done=1.
- Abort:
  - cmd_abort in DATA_ISSUE: go to CS_HOLD immediately.
  - cmd_abort in any other busy state: recorded, and acted on at the next byte boundary (after spi_byte_done).
  - A byte already in flight is still written to the FIFO.
  - FINISH then pulses done with aborted=1.
  - cmd_abort in IDLE has no effect.
- Address: no address arithmetic in the controller; the flash auto-increments.
- Length: LEN_W wide. Maximum 2^LEN_W-1 bytes per command.
- Reset mid-operation: all outputs return to reset values asynchronously; spi_cs_n=1 immediately. No done pulse is generated.
- spi_byte_done outside a wait state is ignored.

Decomposition:
- Shared package flash_pkg: RD_OPCODE constant, state enum type, ADDR_W/LEN_W defaults.
- One natural sub-module, spi_byte_seq: the go/done handshake and byte-index counter for SEND_CMD/SEND_ADDR. Optional; the flat FSM also fits the RTL budget.

Test Plan:
- addr=24'h000100, len=5, FIFO empty, SPI model returns 8'h00..8'h04:
  - MOSI sequence: 03 00 01 00 then 00×5.
  - Five write_req pulses carrying 00,01,02,03,04.
  - FIFO read-back gives 00..04; one done with aborted=0; spi_cs_n high afterwards.
- len=0 -> no spi_go, spi_cs_n constant 1, done one cycle after start, busy high exactly one cycle.
- D=4 FIFO, len=6, no reads until a 200 ns pause:
  - 4 writes, then a stall in DATA_ISSUE with cs_n low and no spi_go.
  - Reading 2 entries resumes the transfer; total writes=6; no overflow.
- len=10, cmd_abort pulsed during byte 3's exchange:
  - Byte 3 is written, no byte 4 is issued.
  - done=1 with aborted=1, exactly 3 write_req pulses.
- system_reset_n low mid-address phase -> spi_cs_n=1 and write_req=0 within the reset assertion. A new cmd_start after reset completes normally.
- cmd_start pulsed while busy -> ignored; the original transfer's byte count and address are unchanged.
